// File: rtl/nco_pkg.sv
// Shared constants, quadrant encoding and quarter-wave table generator for the NCO.
package nco_pkg;

  localparam int unsigned ACC_W     = 32;
  localparam int unsigned PHASE_W   = 12;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned AMP       = 32767;

  localparam int unsigned ROM_AW    = PHASE_W - 2;
  localparam int unsigned ROM_DEPTH = 1 << ROM_AW;
  localparam int unsigned MAG_W     = OUT_W - 1;

  typedef enum logic [1:0] {
    Quad0 = 2'd0,
    Quad1 = 2'd1,
    Quad2 = 2'd2,
    Quad3 = 2'd3
  } quad_e;

  // Half-LSB phase offset keeps every entry in 25..AMP, so no 1025th entry is needed.
  function automatic logic [MAG_W-1:0] quarter_sin(input int unsigned a);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / real'(4 * ROM_DEPTH);
    v   = real'(AMP) * $sin(ang);
    return MAG_W'($rtoi(v + 0.5));
  endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine magnitude ROM with two synchronous read ports (sin and cos).
module nco_quarter_rom
  import nco_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [ROM_AW-1:0] addr_s_i,
  input  logic [ROM_AW-1:0] addr_c_i,
  output logic [MAG_W-1:0]  mag_s_o,
  output logic [MAG_W-1:0]  mag_c_o
);

  logic [MAG_W-1:0] rom [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    assign rom[i] = quarter_sin(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mag_s_o <= '0;
      mag_c_o <= '0;
    end else if (en_i) begin
      mag_s_o <= rom[addr_s_i];
      mag_c_o <= rom[addr_c_i];
    end
  end

endmodule

// File: rtl/nco_core.sv
// Quadrature NCO: 32-bit phase accumulator, quadrant-folded quarter-wave ROM, 3-stage pipeline.
module nco_core
  import nco_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic [ACC_W-1:0] phi_inc_i,
  output logic [OUT_W-1:0] fsin_o,
  output logic [OUT_W-1:0] fcos_o,
  output logic             out_valid
);

  logic [ACC_W-1:0]   acc_q;
  logic [PHASE_W-1:0] ps_q, pc_q;
  logic               neg_s_q, neg_c_q;
  logic [OUT_W-1:0]   fsin_q, fcos_q;
  logic [2:0]         valid_q;
  logic [ROM_AW:0]    fold_s, fold_c;
  logic [MAG_W-1:0]   mag_s, mag_c;
  logic [OUT_W-1:0]   mag_ext_s, mag_ext_c;

  // Returns {negate, rom_address}; odd quadrants read the table mirrored.
  function automatic logic [ROM_AW:0] fold(input logic [PHASE_W-1:0] p);
    logic [ROM_AW-1:0] a;
    a    = p[ROM_AW-1:0];
    fold = '0;
    unique case (quad_e'(p[PHASE_W-1:ROM_AW]))
      Quad0: fold = {1'b0, a};
      Quad1: fold = {1'b0, ~a};
      Quad2: fold = {1'b1, a};
      Quad3: fold = {1'b1, ~a};
    endcase
  endfunction

  always_comb begin
    fold_s    = fold(ps_q);
    fold_c    = fold(pc_q);
    mag_ext_s = {1'b0, mag_s};
    mag_ext_c = {1'b0, mag_c};
  end

  nco_quarter_rom u_rom (
    .clk      (clk),
    .reset    (reset),
    .en_i     (clken),
    .addr_s_i (fold_s[ROM_AW-1:0]),
    .addr_c_i (fold_c[ROM_AW-1:0]),
    .mag_s_o  (mag_s),
    .mag_c_o  (mag_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      ps_q    <= '0;
      pc_q    <= '0;
      neg_s_q <= 1'b0;
      neg_c_q <= 1'b0;
      fsin_q  <= '0;
      fcos_q  <= '0;
      valid_q <= '0;
    end else if (clken) begin
      acc_q   <= acc_q + phi_inc_i;
      ps_q    <= acc_q[ACC_W-1 -: PHASE_W];
      pc_q    <= acc_q[ACC_W-1 -: PHASE_W] + PHASE_W'(ROM_DEPTH);
      neg_s_q <= fold_s[ROM_AW];
      neg_c_q <= fold_c[ROM_AW];
      fsin_q  <= neg_s_q ? -mag_ext_s : mag_ext_s;
      fcos_q  <= neg_c_q ? -mag_ext_c : mag_ext_c;
      valid_q <= {valid_q[1:0], 1'b1};
    end
  end

  assign fsin_o    = fsin_q;
  assign fcos_o    = fcos_q;
  assign out_valid = valid_q[2];

endmodule

// File: tb/tb_nco_core.sv
// Scoreboard bench for nco_core: driver pushes expected samples, monitor pops on each new output.
module tb_nco_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clken = 1'b0;
  logic [31:0] phi_inc_i = '0;
  logic [15:0] fsin_o, fcos_o;
  logic        out_valid;

  nco_core dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int c;
  } samp_t;

  samp_t       sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          last_s = 0;
  int          last_c = 0;
  logic [31:0] model_acc = '0;
  int          hs[4] = '{25, 32767, -25, -32767};
  int          hc[4] = '{32767, -25, -32767, 25};

  function automatic int tbl(input int p);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / 4096.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock edge; returns #1 after the edge.
  task automatic step(input logic [31:0] inc, input bit en, input bit rst, input bit push = 1'b1);
    samp_t e;
    int    p;
    phi_inc_i = inc;
    clken     = en;
    reset     = rst;
    if (!rst && en) begin
      if (push) begin
        p   = int'(model_acc[31:20]);
        e.s = tbl(p);
        e.c = tbl((p + 1024) % 4096);
        sb.push_back(e);
      end
      model_acc = model_acc + inc;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      model_acc = '0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sin"}, $signed(fsin_o), 0);
    check({tag, "_cos"}, $signed(fcos_o), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
  endtask

  task automatic check_fill(input logic [31:0] inc, input string tag);
    for (int i = 1; i <= 3; i++) begin
      step(inc, 1'b1, 1'b0);
      check({tag, "_fill_valid"}, int'(out_valid), (i == 3) ? 1 : 0);
    end
    check({tag, "_s0_sin"}, $signed(fsin_o), 25);
    check({tag, "_s0_cos"}, $signed(fcos_o), 32767);
  endtask

  initial begin : monitor
    bit    adv;
    samp_t e;
    forever begin
      @(posedge clk);
      adv = clken && !reset;
      @(negedge clk);
      if (adv && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          e = sb.pop_front();
          check("sb_sin", $signed(fsin_o), e.s);
          check("sb_cos", $signed(fcos_o), e.c);
          last_s = e.s;
          last_c = e.c;
        end
      end
    end
  end

  initial begin : driver
    // Reset, fill latency and the first arbitrary-frequency samples.
    step(32'h23D7_0A3D, 1'b1, 1'b1);
    check_reset_state("rst");
    check_fill(32'h23D7_0A3D, "init");
    repeat (6) step(32'h23D7_0A3D, 1'b1, 1'b0);

    // Quarter-rate tone: period-4 sequence.
    step(32'h4000_0000, 1'b1, 1'b1);
    for (int e = 1; e <= 11; e++) begin
      step(32'h4000_0000, 1'b1, 1'b0);
      if (e >= 3) begin
        check("q4_sin", $signed(fsin_o), hs[(e - 3) % 4]);
        check("q4_cos", $signed(fcos_o), hc[(e - 3) % 4]);
      end
    end

    // One table step per sample across a full accumulator wrap.
    repeat (4100) step(32'h0010_0000, 1'b1, 1'b0);

    // Clock-enable gap: everything frozen.
    for (int i = 0; i < 5; i++) begin
      step(32'h0010_0000, 1'b0, 1'b0);
      check("hold_valid", int'(out_valid), 1);
      check("hold_sin", $signed(fsin_o), last_s);
      check("hold_cos", $signed(fcos_o), last_c);
    end
    repeat (10) step(32'h0010_0000, 1'b1, 1'b0);

    // Mid-stream reset with clken low: reset still wins.
    step(32'h0010_0000, 1'b0, 1'b1);
    check_reset_state("midrst");
    check_fill(32'h0010_0000, "midrst");

    // Negative frequency.
    repeat (40) step(32'hFFF0_0000, 1'b1, 1'b0);

    // Drain in-flight samples without issuing new expectations.
    repeat (2) step(32'hFFF0_0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
